basic_gates_sync: RTL and testbench

Registered two-input logic-gate unit producing all seven basic Boolean functions (AND, OR, NOT, NAND, NOR, XOR, XNOR) of operands `a` and `b`. Operands are bitwise vectors of configurable width. All results are registered on one clock with a valid flag, so the block drops into any synchronous datapath as a one-cycle logic stage. It is also the reference gate-level block for the digital-design exercise suite.

---
 rtl/basic_gates_pkg.sv | 42 ++++
 rtl/basic_gates_lane.sv | 22 ++
 rtl/basic_gates_sync.sv | 101 ++++++++++
 tb/tb_basic_gates_sync.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/basic_gates_pkg.sv
// Shared constants and a truth-table reference model for the basic_gates block.
package basic_gates_pkg;

  localparam int NUM_GATES = 7;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NOT  = 2;
  localparam int G_NAND = 3;
  localparam int G_NOR  = 4;
  localparam int G_XOR  = 5;
  localparam int G_XNOR = 6;

  localparam int MODEL_W = 32;

  typedef logic [MODEL_W-1:0]                  gate_vec_t;
  typedef logic [NUM_GATES-1:0][MODEL_W-1:0]   gate_set_t;

  // Built from the truth table rather than operators so it is an independent reference.
  function automatic gate_set_t gate_model(input gate_vec_t a, input gate_vec_t b);
    gate_set_t  r;
    logic [6:0] row;
    r = '0;
    for (int i = 0; i < MODEL_W; i++) begin
      case ({a[i], b[i]})
        2'b00:   row = 7'b0011101;
        2'b01:   row = 7'b0111010;
        2'b10:   row = 7'b0101010;
        default: row = 7'b1100001;
      endcase
      r[G_AND][i]  = row[6];
      r[G_OR][i]   = row[5];
      r[G_NOT][i]  = row[4];
      r[G_NAND][i] = row[3];
      r[G_NOR][i]  = row[2];
      r[G_XOR][i]  = row[1];
      r[G_XNOR][i] = row[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/basic_gates_lane.sv
// One-bit combinational slice producing all seven basic gate functions.
module basic_gates_lane (
  input  logic a,
  input  logic b,
  output logic and_y,
  output logic or_y,
  output logic not_y,
  output logic nand_y,
  output logic nor_y,
  output logic xor_y,
  output logic xnor_y
);

  assign and_y  = a & b;
  assign or_y   = a | b;
  assign not_y  = ~a;
  assign nand_y = ~(a & b);
  assign nor_y  = ~(a | b);
  assign xor_y  = a ^ b;
  assign xnor_y = ~(a ^ b);

endmodule

// File: rtl/basic_gates_sync.sv
// Registered bitwise gate unit; one-cycle latency with valid flag.
// Optional registered reduction outputs enabled by BASIC_GATES_REDUCE_EN.
module basic_gates_sync
  import basic_gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] or_out,
  output logic [WIDTH-1:0] not_a,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] nor_out,
  output logic [WIDTH-1:0] xor_out,
`ifdef BASIC_GATES_REDUCE_EN
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
`endif
  output logic [WIDTH-1:0] xnor_out
);

  logic [WIDTH-1:0] and_p0, or_p0, not_p0, nand_p0, nor_p0, xor_p0, xnor_p0;
  logic [WIDTH-1:0] and_p1, or_p1, not_p1, nand_p1, nor_p1, xor_p1, xnor_p1;
  logic             vld_p1;

  // Stage p0: combinational gate lanes
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    basic_gates_lane u_lane (
      .a      (a[i]),
      .b      (b[i]),
      .and_y  (and_p0[i]),
      .or_y   (or_p0[i]),
      .not_y  (not_p0[i]),
      .nand_y (nand_p0[i]),
      .nor_y  (nor_p0[i]),
      .xor_y  (xor_p0[i]),
      .xnor_y (xnor_p0[i])
    );
  end

  // Stage p1: result registers; reset clears data too so inverted outputs read 0
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      and_p1  <= '0;
      or_p1   <= '0;
      not_p1  <= '0;
      nand_p1 <= '0;
      nor_p1  <= '0;
      xor_p1  <= '0;
      xnor_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        and_p1  <= and_p0;
        or_p1   <= or_p0;
        not_p1  <= not_p0;
        nand_p1 <= nand_p0;
        nor_p1  <= nor_p0;
        xor_p1  <= xor_p0;
        xnor_p1 <= xnor_p0;
      end
    end
  end

`ifdef BASIC_GATES_REDUCE_EN
  logic red_and_p1, red_or_p1, red_xor_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      red_and_p1 <= 1'b0;
      red_or_p1  <= 1'b0;
      red_xor_p1 <= 1'b0;
    end else if (in_valid) begin
      red_and_p1 <= &and_p0;
      red_or_p1  <= |or_p0;
      red_xor_p1 <= ^xor_p0;
    end
  end

  assign red_and = red_and_p1;
  assign red_or  = red_or_p1;
  assign red_xor = red_xor_p1;
`endif

  assign out_valid = vld_p1;
  assign and_out   = and_p1;
  assign or_out    = or_p1;
  assign not_a     = not_p1;
  assign nand_out  = nand_p1;
  assign nor_out   = nor_p1;
  assign xor_out   = xor_p1;
  assign xnor_out  = xnor_p1;

endmodule

// File: tb/tb_basic_gates_sync.sv
// Directed bench for basic_gates_sync at WIDTH=1, 8 and 4.
module tb_basic_gates_sync;
  import basic_gates_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;

  logic       a1, b1;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;

  logic       v1, v8, v4;
  logic       and1, or1, not1, nand1, nor1, xor1, xnor1;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
  logic [3:0] and4, or4, not4, nand4, nor4, xor4, xnor4;
`ifdef BASIC_GATES_REDUCE_EN
  logic ra1, ro1, rx1, ra8, ro8, rx8, ra4, ro4, rx4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  basic_gates_sync #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(v1), .and_out(and1), .or_out(or1), .not_a(not1),
    .nand_out(nand1), .nor_out(nor1), .xor_out(xor1),
`ifdef BASIC_GATES_REDUCE_EN
    .red_and(ra1), .red_or(ro1), .red_xor(rx1),
`endif
    .xnor_out(xnor1)
  );

  basic_gates_sync #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(v8), .and_out(and8), .or_out(or8), .not_a(not8),
    .nand_out(nand8), .nor_out(nor8), .xor_out(xor8),
`ifdef BASIC_GATES_REDUCE_EN
    .red_and(ra8), .red_or(ro8), .red_xor(rx8),
`endif
    .xnor_out(xnor8)
  );

  basic_gates_sync #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(v4), .and_out(and4), .or_out(or4), .not_a(not4),
    .nand_out(nand4), .nor_out(nor4), .xor_out(xor4),
`ifdef BASIC_GATES_REDUCE_EN
    .red_and(ra4), .red_or(ro4), .red_xor(rx4),
`endif
    .xnor_out(xnor4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // row is {and,or,not,nand,nor,xor,xnor}, MSB first, as in the truth table
  task automatic check_u1(input string tag, input logic [6:0] row, input logic ev);
    check({tag, "/vld"},  32'(v1),    32'(ev));
    check({tag, "/and"},  32'(and1),  32'(row[6]));
    check({tag, "/or"},   32'(or1),   32'(row[5]));
    check({tag, "/not"},  32'(not1),  32'(row[4]));
    check({tag, "/nand"}, 32'(nand1), 32'(row[3]));
    check({tag, "/nor"},  32'(nor1),  32'(row[2]));
    check({tag, "/xor"},  32'(xor1),  32'(row[1]));
    check({tag, "/xnor"}, 32'(xnor1), 32'(row[0]));
  endtask

  task automatic check_u8(input string tag, input logic ev,
                          input logic [7:0] e_and, input logic [7:0] e_or,
                          input logic [7:0] e_not, input logic [7:0] e_nand,
                          input logic [7:0] e_nor, input logic [7:0] e_xor,
                          input logic [7:0] e_xnor);
    check({tag, "/vld"},  32'(v8),    32'(ev));
    check({tag, "/and"},  32'(and8),  32'(e_and));
    check({tag, "/or"},   32'(or8),   32'(e_or));
    check({tag, "/not"},  32'(not8),  32'(e_not));
    check({tag, "/nand"}, 32'(nand8), 32'(e_nand));
    check({tag, "/nor"},  32'(nor8),  32'(e_nor));
    check({tag, "/xor"},  32'(xor8),  32'(e_xor));
    check({tag, "/xnor"}, 32'(xnor8), 32'(e_xnor));
  endtask

  task automatic check_u8_model(input string tag, input logic [7:0] oa, input logic [7:0] ob);
    gate_set_t m;
    m = gate_model(gate_vec_t'(oa), gate_vec_t'(ob));
    check_u8(tag, 1'b1, m[G_AND][7:0], m[G_OR][7:0], m[G_NOT][7:0], m[G_NAND][7:0],
             m[G_NOR][7:0], m[G_XOR][7:0], m[G_XNOR][7:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] tt [4];
  logic [7:0] ra, rb;

  initial begin
    tt[0] = 7'b0011101;
    tt[1] = 7'b0111010;
    tt[2] = 7'b0101010;
    tt[3] = 7'b1100001;

    // Reset has priority over a valid all-ones input
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; a4 = 4'hF; b4 = 4'hF;
    tick();
    check_u1("rst1", 7'b0, 1'b0);
    tick();
    check_u1("rst2", 7'b0, 1'b0);
    check_u8("rst2_w8", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst2_w4/not", 32'(not4), 32'h0);
`ifdef BASIC_GATES_REDUCE_EN
    check("rst2_w4/red_and", 32'(ra4), 32'h0);
    check("rst2_w4/red_or",  32'(ro4), 32'h0);
    check("rst2_w4/red_xor", 32'(rx4), 32'h0);
`endif

    // Exhaustive truth table at WIDTH=1
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      tick();
      check_u1($sformatf("tt%0d", i), tt[i], 1'b1);
    end

    // Hold: invalid input must not disturb the registered results
    a1 = 1'b0; b1 = 1'b1; in_valid = 1'b1;
    tick();
    check_u1("hold_load", tt[1], 1'b1);
    a1 = 1'b1; b1 = 1'b1; in_valid = 1'b0;
    tick();
    check_u1("hold1", tt[1], 1'b0);
    a1 = 1'b0; b1 = 1'b0;
    tick();
    check_u1("hold2", tt[1], 1'b0);

    // Wide operands at WIDTH=8
    in_valid = 1'b1; a8 = 8'hF0; b8 = 8'hAA;
    tick();
    check_u8("wide", 1'b1, 8'hA0, 8'hFA, 8'h0F, 8'h5F, 8'h05, 8'h5A, 8'hA5);

    // WIDTH=4 vectors, including reductions when present
    a4 = 4'hF; b4 = 4'hF;
    tick();
    check("w4_ff/vld", 32'(v4), 32'h1);
    check("w4_ff/and", 32'(and4), 32'hF);
    check("w4_ff/xnor", 32'(xnor4), 32'hF);
`ifdef BASIC_GATES_REDUCE_EN
    check("w4_ff/red_and", 32'(ra4), 32'h1);
    check("w4_ff/red_or",  32'(ro4), 32'h1);
    check("w4_ff/red_xor", 32'(rx4), 32'h0);
`endif
    a4 = 4'h1; b4 = 4'h0;
    tick();
    check("w4_10/xor", 32'(xor4), 32'h1);
    check("w4_10/nor", 32'(nor4), 32'hE);
`ifdef BASIC_GATES_REDUCE_EN
    check("w4_10/red_and", 32'(ra4), 32'h0);
    check("w4_10/red_or",  32'(ro4), 32'h1);
    check("w4_10/red_xor", 32'(rx4), 32'h1);
`endif

    // Random stream, then a one-cycle reset mid-stream
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      a8 = ra; b8 = rb;
      tick();
      check_u8_model($sformatf("rnd%0d", i), ra, rb);
    end
    rst = 1'b1;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    tick();
    check_u8("mid_rst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_u1("mid_rst_w1", 7'b0, 1'b0);
    rst = 1'b0;
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    a8 = ra; b8 = rb;
    tick();
    check_u8_model("post_rst", ra, rb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
